// File: rtl/sd_bin_writer_if.sv
// sd_bin_writer_if: BRAM read port plus sd_controller write side seen by sd_bin_writer
interface sd_bin_writer_if;
  logic [18:0] bram_addr;
  logic [2:0]  bram_dout;
  logic        sd_ready;
  logic        sd_ready_for_next_byte;
  logic        sd_wr;
  logic [7:0]  sd_din;
  logic [31:0] sd_addr;
  modport master (output bram_addr, sd_wr, sd_din, sd_addr, input bram_dout, sd_ready, sd_ready_for_next_byte);
  modport slave  (input bram_addr, sd_wr, sd_din, sd_addr, output bram_dout, sd_ready, sd_ready_for_next_byte);
endinterface

// File: rtl/sd_bin_writer.sv
// sd_bin_writer: streams xy_bin BRAM bins into SD sectors, zero-padding the last one.
// SD_BIN_PACK2_EN packs two pixels per byte (even pixel in the low nibble).
module sd_bin_writer #(
  parameter int NUM_PIXELS = 307200,
  parameter int BRAM_LAT   = 2,
  parameter int SECT_BYTES = 512,
  parameter int ADDR_STEP  = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  output logic        busy,
  output logic        done,
  output logic [15:0] sectors_written,
  sd_bin_writer_if.master bus
);
`ifdef SD_BIN_PACK2_EN
  localparam bit PACK2 = 1'b1;
`else
  localparam bit PACK2 = 1'b0;
`endif
  localparam int BW = $clog2(SECT_BYTES + 1);
  localparam int LW = $clog2(BRAM_LAT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_RDY, STREAM, SECT_WAIT, DONE} state_t;
  state_t        state;
  logic [19:0]   pix;
  logic [BW-1:0] byte_cnt;
  logic [LW-1:0] lat_cnt;
  logic          rfnb_q, seen_low, half;
  logic [3:0]    lo;
  logic          end_pix, rfnb_rise;
  logic [2:0]    bin;
  assign end_pix   = pix >= 20'(NUM_PIXELS);
  assign rfnb_rise = bus.sd_ready_for_next_byte & ~rfnb_q;
  assign bin       = end_pix ? 3'd0 : bus.bram_dout;
  assign bus.bram_addr = pix[18:0];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      pix             <= '0;
      byte_cnt        <= '0;
      lat_cnt         <= '0;
      rfnb_q          <= 1'b0;
      seen_low        <= 1'b0;
      half            <= 1'b0;
      lo              <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      sectors_written <= '0;
      bus.sd_wr       <= 1'b0;
      bus.sd_din      <= '0;
      bus.sd_addr     <= '0;
    end else begin
      rfnb_q <= bus.sd_ready_for_next_byte;
      case (state)
        IDLE: if (start) begin
          bus.sd_addr     <= base_addr;
          pix             <= '0;
          byte_cnt        <= '0;
          lat_cnt         <= '0;
          half            <= 1'b0;
          sectors_written <= '0;
          busy            <= 1'b1;
          done            <= 1'b0;
          state           <= FETCH;
        end
        FETCH: begin
          // pix drives bram_addr directly, so each read waits BRAM_LAT cycles after pix settles
          if (!end_pix && lat_cnt != LW'(BRAM_LAT)) lat_cnt <= lat_cnt + 1'b1;
          else begin
            lat_cnt <= '0;
            if (!end_pix) pix <= pix + 1'b1;
            if (PACK2 && !half) begin
              half <= 1'b1;
              lo   <= {1'b0, bin};
            end else begin
              half       <= 1'b0;
              bus.sd_din <= PACK2 ? {1'b0, bin, lo} : {5'b0, bin};
              state      <= byte_cnt == '0 ? WAIT_RDY : STREAM;
            end
          end
        end
        WAIT_RDY: if (bus.sd_ready) begin
          bus.sd_wr <= 1'b1;
          state     <= STREAM;
        end
        STREAM: if (rfnb_rise) begin
          byte_cnt <= byte_cnt + 1'b1;
          if (byte_cnt == BW'(SECT_BYTES - 1)) begin
            bus.sd_wr <= 1'b0;
            seen_low  <= 1'b0;
            state     <= SECT_WAIT;
          end else state <= FETCH;
        end
        SECT_WAIT: begin
          // the card reports the sector committed by dropping then raising ready
          if (!bus.sd_ready) seen_low <= 1'b1;
          else if (seen_low) begin
            sectors_written <= sectors_written + 1'b1;
            if (end_pix) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              bus.sd_addr <= bus.sd_addr + 32'(ADDR_STEP);
              byte_cnt    <= '0;
              state       <= FETCH;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
